// File: rtl/cnn_pkg.sv
// Shared fixed-point helpers for the CNN layer blocks: Q16.16 constants, the
// sequencer state type and the store-stage saturate/ReLU function.
package cnn_pkg;

    localparam int          FRAC_BITS = 16;
    localparam logic [31:0] ONE       = 32'h0001_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_STORE
    } state_e;

    // Optionally clamps x to [-2^msb, 2^msb-1], then zeroes non-positive values when relu_en is set.
    function automatic logic signed [63:0] sat_relu(
        input logic signed [63:0] x,
        input int                 msb,
        input logic               sat_en,
        input logic               relu_en
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] y;
        hi = (64'sd1 <<< msb) - 64'sd1;
        lo = -(64'sd1 <<< msb);
        y  = x;
        if (sat_en) begin
            if (x > hi) begin
                y = hi;
            end else if (x < lo) begin
                y = lo;
            end
        end
        if (relu_en && (y <= 64'sd0)) begin
            y = '0;
        end
        return y;
    endfunction

endpackage

// File: rtl/tconv_tap_decode.sv
// Maps an output position and kernel tap to a validity flag, a flat input
// index and the filter-0 weight offset for the gather-form transposed conv.
module tconv_tap_decode #(
    parameter int IN_H     = 7,
    parameter int IN_W     = 7,
    parameter int IN_CH    = 4,
    parameter int OUT_CH   = 1,
    parameter int KERNEL_H = 3,
    parameter int KERNEL_W = 3,
    parameter int STRIDE   = 1,
    parameter int OUT_W    = (IN_W - 1) * STRIDE + KERNEL_W,
    parameter int POS_W    = 6,
    parameter int TAP_W    = 6,
    parameter int DIDX_W   = 8,
    parameter int WOFF_W   = 6
) (
    input  logic [POS_W-1:0]  pos,
    input  logic [TAP_W-1:0]  tap,
    output logic              valid,
    output logic [DIDX_W-1:0] data_idx,
    output logic [WOFF_W-1:0] weight_off
);

    localparam int unsigned IH = IN_H;
    localparam int unsigned IW = IN_W;
    localparam int unsigned OC = OUT_CH;
    localparam int unsigned KH = KERNEL_H;
    localparam int unsigned KW = KERNEL_W;
    localparam int unsigned ST = STRIDE;
    localparam int unsigned OW = OUT_W;

    int unsigned out_r;
    int unsigned out_c;
    int unsigned ch;
    int unsigned kr;
    int unsigned kc;
    int unsigned dr;
    int unsigned dc;
    logic        row_ok;
    logic        col_ok;

    // A tap only lands if the output coordinate lies on the stride grid of a real input pixel.
    always_comb begin
        out_r  = 32'(pos) / OW;
        out_c  = 32'(pos) % OW;
        ch     = 32'(tap) / (KH * KW);
        kr     = (32'(tap) / KW) % KH;
        kc     = 32'(tap) % KW;
        dr     = out_r - kr;
        dc     = out_c - kc;
        row_ok = (out_r >= kr) && ((dr % ST) == 0) && ((dr / ST) < IH);
        col_ok = (out_c >= kc) && ((dc % ST) == 0) && ((dc / ST) < IW);
        valid  = row_ok && col_ok;
        data_idx   = valid ? DIDX_W'(ch * IH * IW + (dr / ST) * IW + (dc / ST)) : '0;
        weight_off = WOFF_W'(ch * OC * KH * KW + kr * KW + kc);
    end

endmodule

// File: rtl/conv2d_transpose.sv
// Sequential gather-form 2D transposed convolution, one MAC per output filter.
// Build option: define CONV2D_TRANSPOSE_SATURATE_EN to clamp stores instead of wrapping.
module conv2d_transpose
    import cnn_pkg::*;
#(
    parameter int IN_H     = 7,
    parameter int IN_W     = 7,
    parameter int IN_CH    = 4,
    parameter int OUT_CH   = 1,
    parameter int KERNEL_H = 3,
    parameter int KERNEL_W = 3,
    parameter int STRIDE   = 1,
    parameter int OUT_H    = (IN_H - 1) * STRIDE + KERNEL_H,
    parameter int OUT_W    = (IN_W - 1) * STRIDE + KERNEL_W,
    parameter int BITS     = 31
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   activation_function,
    input  logic signed [BITS:0]   data_in  [IN_CH*IN_H*IN_W],
    input  logic signed [31:0]     weights  [IN_CH*OUT_CH*KERNEL_H*KERNEL_W],
    input  logic signed [31:0]     bias     [OUT_CH],
    output logic signed [BITS:0]   data_out [OUT_CH*OUT_H*OUT_W],
    output logic                   busy,
    output logic                   done
);

    localparam int TAP_COUNT  = IN_CH * KERNEL_H * KERNEL_W;
    localparam int POS_COUNT  = OUT_H * OUT_W;
    localparam int DATA_COUNT = IN_CH * IN_H * IN_W;
    localparam int W_COUNT    = IN_CH * OUT_CH * KERNEL_H * KERNEL_W;
    localparam int OUT_COUNT  = OUT_CH * POS_COUNT;
    localparam int DW         = BITS + 1;
    localparam int ACC_W      = BITS + 25;
    localparam int SUM_W      = ACC_W + 1;
    localparam int PROD_W     = DW + 32;
    localparam int POS_W      = (POS_COUNT  > 1) ? $clog2(POS_COUNT)  : 1;
    localparam int TAP_W      = (TAP_COUNT  > 1) ? $clog2(TAP_COUNT)  : 1;
    localparam int DIDX_W     = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
    localparam int WIDX_W     = (W_COUNT    > 1) ? $clog2(W_COUNT)    : 1;
    localparam int OIDX_W     = (OUT_COUNT  > 1) ? $clog2(OUT_COUNT)  : 1;

`ifdef CONV2D_TRANSPOSE_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_e                    state_q, state_d;
    logic [POS_W-1:0]          pos_q, pos_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic signed [ACC_W-1:0]   acc_q [OUT_CH];
    logic signed [ACC_W-1:0]   acc_d [OUT_CH];
    logic signed [BITS:0]      data_out_q [OUT_COUNT];
    logic signed [BITS:0]      data_out_d [OUT_COUNT];
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      tap_valid;
    logic [DIDX_W-1:0]         data_idx;
    logic [WIDX_W-1:0]         weight_off;
    logic signed [BITS:0]      d_sel;
    logic signed [31:0]        w_sel   [OUT_CH];
    logic signed [PROD_W-1:0]  prod    [OUT_CH];
    logic signed [PROD_W-1:0]  prod_sh [OUT_CH];
    logic signed [ACC_W-1:0]   contrib [OUT_CH];
    logic signed [SUM_W-1:0]   sum     [OUT_CH];
    logic signed [BITS:0]      result  [OUT_CH];

    tconv_tap_decode #(
        .IN_H     (IN_H),
        .IN_W     (IN_W),
        .IN_CH    (IN_CH),
        .OUT_CH   (OUT_CH),
        .KERNEL_H (KERNEL_H),
        .KERNEL_W (KERNEL_W),
        .STRIDE   (STRIDE),
        .OUT_W    (OUT_W),
        .POS_W    (POS_W),
        .TAP_W    (TAP_W),
        .DIDX_W   (DIDX_W),
        .WOFF_W   (WIDX_W)
    ) u_decode (
        .pos        (pos_q),
        .tap        (tap_q),
        .valid      (tap_valid),
        .data_idx   (data_idx),
        .weight_off (weight_off)
    );

    // Invalid taps read data index 0 but are masked so they contribute exactly zero.
    always_comb begin
        d_sel = data_in[data_idx];
        for (int f = 0; f < OUT_CH; f++) begin
            w_sel[f]   = weights[weight_off + WIDX_W'(f * KERNEL_H * KERNEL_W)];
            prod[f]    = PROD_W'(d_sel) * PROD_W'(w_sel[f]);
            prod_sh[f] = prod[f] >>> FRAC_BITS;
            contrib[f] = tap_valid ? ACC_W'(prod_sh[f]) : '0;
            sum[f]     = SUM_W'(acc_q[f]) + SUM_W'(bias[f]);
            result[f]  = DW'(sat_relu(64'(sum[f]), BITS, SAT_EN, activation_function));
        end
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        case (state_q)
            S_IDLE: begin
                pos_d = '0;
                tap_d = '0;
                for (int f = 0; f < OUT_CH; f++) begin
                    acc_d[f] = '0;
                end
                if (start) begin
                    state_d = S_COMPUTE;
                    busy_d  = 1'b1;
                end
            end
            S_COMPUTE: begin
                for (int f = 0; f < OUT_CH; f++) begin
                    acc_d[f] = acc_q[f] + contrib[f];
                end
                if (tap_q == TAP_W'(TAP_COUNT - 1)) begin
                    tap_d   = '0;
                    state_d = S_STORE;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_STORE: begin
                for (int f = 0; f < OUT_CH; f++) begin
                    data_out_d[OIDX_W'(f * POS_COUNT) + OIDX_W'(pos_q)] = result[f];
                    acc_d[f] = '0;
                end
                if (pos_q == POS_W'(POS_COUNT - 1)) begin
                    pos_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    pos_d   = pos_q + POS_W'(1);
                    state_d = S_COMPUTE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            tap_q      <= '0;
            acc_q      <= '{default: '0};
            data_out_q <= '{default: '0};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_conv2d_transpose.sv
// Directed bench for conv2d_transpose: a stride-1 and a stride-2 instance
// driven with hand-computed Q16.16 vectors.
module tb_conv2d_transpose;

    localparam logic signed [31:0] ONE_Q = 32'sh0001_0000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic act = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic signed [31:0] data_a [4];
    logic signed [31:0] w_a    [4];
    logic signed [31:0] data_b [4];
    logic signed [31:0] w_b    [4];
    logic signed [31:0] bias   [1];
    logic signed [31:0] out_a  [9];
    logic signed [31:0] out_b  [16];
    logic busy_a, done_a, busy_b, done_b;

    int tests_run = 0;
    int tests_failed = 0;
    int taps_a [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    int blk_b [16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};

    always #5 clk = ~clk;

    conv2d_transpose #(
        .IN_H(2), .IN_W(2), .IN_CH(1), .OUT_CH(1),
        .KERNEL_H(2), .KERNEL_W(2), .STRIDE(1), .BITS(31)
    ) dut_a (
        .clk                 (clk),
        .rstn                (rstn),
        .start               (start_a),
        .activation_function (act),
        .data_in             (data_a),
        .weights             (w_a),
        .bias                (bias),
        .data_out            (out_a),
        .busy                (busy_a),
        .done                (done_a)
    );

    conv2d_transpose #(
        .IN_H(2), .IN_W(2), .IN_CH(1), .OUT_CH(1),
        .KERNEL_H(2), .KERNEL_W(2), .STRIDE(2), .BITS(31)
    ) dut_b (
        .clk                 (clk),
        .rstn                (rstn),
        .start               (start_b),
        .activation_function (act),
        .data_in             (data_b),
        .weights             (w_b),
        .bias                (bias),
        .data_out            (out_b),
        .busy                (busy_b),
        .done                (done_b)
    );

    // Pulses start for one sampled edge, then counts edges until done is seen.
    task automatic run_pass_a(input int limit, output int lat);
        lat = -1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (done_a) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_pass_b(input int limit, output int lat);
        lat = -1;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (done_b) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic load_unit_a();
        for (int i = 0; i < 4; i++) begin
            data_a[i] = ONE_Q;
            w_a[i]    = ONE_Q;
        end
        bias[0] = 32'sh0;
        act     = 1'b1;
    endtask

    task automatic test_reset();
        int nz;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nz = 0;
        for (int i = 0; i < 9; i++) if (out_a[i] !== 32'sh0) nz++;
        tests_run++;
        if (busy_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy_a); end
        tests_run++;
        if (done_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b, expected 0", done_a); end
        tests_run++;
        if (nz !== 0) begin tests_failed++; $display("[TB] FAIL reset_data_out: %0d nonzero entries, expected 0", nz); end
        rstn = 1'b1;
    endtask

    task automatic test_unit_stride();
        int lat;
        load_unit_a();
        run_pass_a(200, lat);
        tests_run++;
        if (lat !== 45) begin tests_failed++; $display("[TB] FAIL s1_latency: got %0d, expected 45", lat); end
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (out_a[i] !== (32'(taps_a[i]) <<< 16)) begin
                tests_failed++;
                $display("[TB] FAIL s1_out[%0d]: got %h, expected %h", i, out_a[i], 32'(taps_a[i]) <<< 16);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL s1_done_pulse: done=%b busy=%b, expected 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_stride2();
        int lat;
        for (int i = 0; i < 4; i++) begin
            data_b[i] = 32'(i + 1) <<< 16;
            w_b[i]    = ONE_Q;
        end
        bias[0] = 32'sh0;
        act     = 1'b1;
        run_pass_b(300, lat);
        tests_run++;
        if (lat !== 80) begin tests_failed++; $display("[TB] FAIL s2_latency: got %0d, expected 80", lat); end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (out_b[i] !== (32'(blk_b[i]) <<< 16)) begin
                tests_failed++;
                $display("[TB] FAIL s2_out[%0d]: got %h, expected %h", i, out_b[i], 32'(blk_b[i]) <<< 16);
            end
        end
    endtask

    task automatic test_negative();
        int lat;
        logic signed [31:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            data_a[i] = ONE_Q;
            w_a[i]    = -ONE_Q;
        end
        bias[0] = 32'sh0000_8000;
        act     = 1'b1;
        run_pass_a(200, lat);
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (out_a[i] !== 32'sh0) begin
                tests_failed++;
                $display("[TB] FAIL neg_relu_out[%0d]: got %h, expected 0", i, out_a[i]);
            end
        end
        act = 1'b0;
        run_pass_a(200, lat);
        for (int i = 0; i < 9; i++) begin
            exp_v = 32'sh0000_8000 - (32'(taps_a[i]) <<< 16);
            tests_run++;
            if (out_a[i] !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL neg_lin_out[%0d]: got %h, expected %h", i, out_a[i], exp_v);
            end
        end
        tests_run++;
        if (out_a[0] !== 32'hFFFF_8000) begin
            tests_failed++;
            $display("[TB] FAIL neg_corner: got %h, expected ffff8000", out_a[0]);
        end
    endtask

    task automatic test_saturate();
        int lat;
        logic [63:0] wide;
        logic [31:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            data_a[i] = 32'sh7FFF_0000;
            w_a[i]    = 32'sh0004_0000;
        end
        bias[0] = 32'sh0;
        act     = 1'b1;
        run_pass_a(200, lat);
        for (int i = 0; i < 9; i++) begin
            wide = 64'(taps_a[i]) * 64'h1_FFFC_0000;
`ifdef CONV2D_TRANSPOSE_SATURATE_EN
            exp_v = 32'h7FFF_FFFF;
`else
            exp_v = wide[31:0];
`endif
            tests_run++;
            if (out_a[i] !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL sat_out[%0d]: got %h, expected %h", i, out_a[i], exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        int lat;
        int nz;
        load_unit_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (10) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk); #1;
        nz = 0;
        for (int i = 0; i < 9; i++) if (out_a[i] !== 32'sh0) nz++;
        tests_run++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_flags: busy=%b done=%b, expected 0 0", busy_a, done_a);
        end
        tests_run++;
        if (nz !== 0) begin tests_failed++; $display("[TB] FAIL midreset_data_out: %0d nonzero entries, expected 0", nz); end
        rstn = 1'b1;
        run_pass_a(200, lat);
        tests_run++;
        if (lat !== 45) begin tests_failed++; $display("[TB] FAIL midreset_latency: got %0d, expected 45", lat); end
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (out_a[i] !== (32'(taps_a[i]) <<< 16)) begin
                tests_failed++;
                $display("[TB] FAIL midreset_out[%0d]: got %h, expected %h", i, out_a[i], 32'(taps_a[i]) <<< 16);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int ndone;
        int first;
        ndone = 0;
        first = -1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk); #1;
            if (done_a) begin
                ndone++;
                if (first < 0) first = i;
            end
            if (i == 10) start_a = 1'b1;
            else if (i == 11) start_a = 1'b0;
        end
        tests_run++;
        if (first !== 45) begin tests_failed++; $display("[TB] FAIL busy_start_latency: got %0d, expected 45", first); end
        tests_run++;
        if (ndone !== 1) begin tests_failed++; $display("[TB] FAIL busy_start_dones: got %0d, expected 1", ndone); end
    endtask

    // With start held, the next pass is sampled on the edge after done, so dones are 46 edges apart.
    task automatic test_back_to_back();
        int first;
        int gap;
        first = -1;
        gap   = -1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done_a) begin first = i; break; end
        end
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done_a) begin gap = i; break; end
        end
        start_a = 1'b0;
        tests_run++;
        if (first !== 45) begin tests_failed++; $display("[TB] FAIL b2b_first: got %0d, expected 45", first); end
        tests_run++;
        if (gap !== 46) begin tests_failed++; $display("[TB] FAIL b2b_gap: got %0d, expected 46", gap); end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_stop: busy=%b, expected 0", busy_a); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            data_a[i] = '0;
            w_a[i]    = '0;
            data_b[i] = '0;
            w_b[i]    = '0;
        end
        bias[0] = '0;
        test_reset();
        test_unit_stride();
        test_stride2();
        test_negative();
        test_saturate();
        test_reset_mid_pass();
        test_start_while_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
